store_buffer: RTL and testbench

- FIFO store buffer between the MEM-stage pipeline register and the byte-addressed data memory (14-bit byte address, MemDst size encoding 0=byte, 1=half, 3=word).
- Decouples stores from the single DM address port.
- Loads get the port with priority; buffered stores drain in free cycles.
- Loads that hit a pending store's word stall until that word has drained.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/sb_fifo.sv | 38 +++
 rtl/store_buffer.sv | 113 +++++++++++
 tb/tb_store_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - DM size encodings, store-buffer entry type and the store alignment check
package mem_pkg;

    localparam logic [1:0] MEMDST_BYTE = 2'd0;
    localparam logic [1:0] MEMDST_HALF = 2'd1;
    localparam logic [1:0] MEMDST_WORD = 2'd3;

    localparam int DM_ADDR_W = 14;

    typedef struct packed {
        logic [DM_ADDR_W-1:0] addr;
        logic [1:0]           size;
        logic [31:0]          data;
        logic [31:0]          pc;
    } sb_entry_t;

    // Size 2 has no DM meaning, so it is reported as an error alongside misalignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MEMDST_BYTE: return 1'b0;
            MEMDST_HALF: return addr_lo[0];
            MEMDST_WORD: return addr_lo != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// rtl/sb_fifo.sv - circular entry storage with push/pop, wrapping pointers and an occupancy count
module sb_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [31:0]
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] tail;

    // Callers only push when not full and only pop when not empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) entries[tail] <= push_data;
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store buffer between MEM stage and DM; STORE_BUFFER_FWD_EN adds word forwarding
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = DM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [1:0]        st_size,
    input  logic [31:0]       st_data,
    input  logic [31:0]       st_pc,
    output logic              st_ready,
    output logic              st_err,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    output logic              ld_stall,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [1:0]        dm_memdst,
    output logic [31:0]       dm_wdata,
    output logic [31:0]       dm_iaddr,
`ifdef STORE_BUFFER_FWD_EN
    output logic              ld_fwd,
    output logic [31:0]       ld_fwd_data,
`endif
    output logic              sb_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        entries [DEPTH];
    sb_entry_t        head_entry;
    sb_entry_t        push_entry;
    logic [PTR_W-1:0] head;
    logic [CNT_W-1:0] count;
    logic             push, pop, hit, full_drain, load_own, fwd_ok;
`ifdef STORE_BUFFER_FWD_EN
    sb_entry_t        youngest;
`endif

    assign st_err     = st_valid && misaligned(st_size, st_addr[1:0]);
    assign st_ready   = (count < CNT_W'(DEPTH)) && !st_err;
    assign push       = st_valid && st_ready;
    assign push_entry = '{addr: st_addr, size: st_size, data: st_data, pc: st_pc};
    assign head_entry = entries[head];
    assign sb_empty   = (count == '0);
    assign full_drain = (count == CNT_W'(DEPTH));

    // Walk oldest to youngest so the last match is the youngest pending store.
    always_comb begin
        hit = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        youngest = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] idx;
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count && entries[idx].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
                hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                youngest = entries[idx];
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign fwd_ok      = ld_valid && hit && youngest.size == MEMDST_WORD && ld_size == MEMDST_WORD;
    assign ld_fwd      = fwd_ok;
    assign ld_fwd_data = fwd_ok ? youngest.data : 32'd0;
`else
    assign fwd_ok      = 1'b0;
`endif

    // A forwarded load needs no DM access, so the port is free to drain.
    assign ld_stall = ld_valid && !fwd_ok && (hit || full_drain);
    assign load_own = ld_valid && !ld_stall && !fwd_ok;
    assign pop      = !load_own && !sb_empty;

    always_comb begin
        dm_we     = pop;
        dm_addr   = ld_addr;
        dm_memdst = ld_size;
        dm_wdata  = 32'd0;
        dm_iaddr  = 32'd0;
        if (pop) begin
            dm_addr   = head_entry.addr;
            dm_memdst = head_entry.size;
            dm_wdata  = head_entry.data;
            dm_iaddr  = head_entry.pc;
        end
    end

    sb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (sb_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .entries   (entries),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer (optionally with STORE_BUFFER_FWD_EN)
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          st_valid = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [1:0]    st_size = '0;
    logic [31:0]   st_data = '0;
    logic [31:0]   st_pc = '0;
    logic          st_ready, st_err;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [1:0]    ld_size = '0;
    logic          ld_stall, dm_we, sb_empty;
    logic [AW-1:0] dm_addr;
    logic [1:0]    dm_memdst;
    logic [31:0]   dm_wdata, dm_iaddr;
`ifdef STORE_BUFFER_FWD_EN
    logic          ld_fwd;
    logic [31:0]   ld_fwd_data;
`endif

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_size     (st_size),
        .st_data     (st_data),
        .st_pc       (st_pc),
        .st_ready    (st_ready),
        .st_err      (st_err),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_size     (ld_size),
        .ld_stall    (ld_stall),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_memdst   (dm_memdst),
        .dm_wdata    (dm_wdata),
        .dm_iaddr    (dm_iaddr),
`ifdef STORE_BUFFER_FWD_EN
        .ld_fwd      (ld_fwd),
        .ld_fwd_data (ld_fwd_data),
`endif
        .sb_empty    (sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [1:0]    s;
        logic [31:0]   d;
        logic [31:0]   pc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output at the falling edge, then retire/enqueue in the model at the rising edge.
    task automatic step();
        logic mis, e_err, e_rdy, hit, full, e_stall, own, e_we, fwd;
        exp_t y;
        @(negedge clk);
        mis   = (st_size == 2'd2) || (st_size == 2'd1 && st_addr[0]) ||
                (st_size == 2'd3 && st_addr[1:0] != 2'b00);
        e_err = st_valid && mis;
        e_rdy = (q.size() < DEPTH) && !e_err;
        hit   = 1'b0;
        y     = '{a: '0, s: '0, d: '0, pc: '0};
        foreach (q[i]) begin
            if (q[i].a[AW-1:2] == ld_addr[AW-1:2]) begin
                hit = 1'b1;
                y   = q[i];
            end
        end
        full = (q.size() == DEPTH);
        fwd  = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        fwd  = ld_valid && hit && y.s == 2'd3 && ld_size == 2'd3;
        check_val("ld_fwd", 32'(ld_fwd), 32'(fwd));
        check_val("ld_fwd_data", ld_fwd_data, fwd ? y.d : 32'd0);
`endif
        e_stall = ld_valid && !fwd && (hit || full);
        own     = ld_valid && !e_stall && !fwd;
        e_we    = !own && q.size() > 0;
        check_val("st_err", 32'(st_err), 32'(e_err));
        check_val("st_ready", 32'(st_ready), 32'(e_rdy));
        check_val("ld_stall", 32'(ld_stall), 32'(e_stall));
        check_val("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
        check_val("dm_we", 32'(dm_we), 32'(e_we));
        if (e_we) begin
            check_val("dm_addr", 32'(dm_addr), 32'(q[0].a));
            check_val("dm_memdst", 32'(dm_memdst), 32'(q[0].s));
            check_val("dm_wdata", dm_wdata, q[0].d);
            check_val("dm_iaddr", dm_iaddr, q[0].pc);
        end else begin
            check_val("dm_addr_ld", 32'(dm_addr), 32'(ld_addr));
            check_val("dm_memdst_ld", 32'(dm_memdst), 32'(ld_size));
            check_val("dm_wdata_idle", dm_wdata, 32'd0);
            check_val("dm_iaddr_idle", dm_iaddr, 32'd0);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            if (e_we) void'(q.pop_front());
            if (st_valid && e_rdy) q.push_back('{a: st_addr, s: st_size, d: st_data, pc: st_pc});
        end
    endtask

    task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [1:0] ss,
                         input logic [31:0] sd, input logic lv, input logic [AW-1:0] la,
                         input logic [1:0] ls);
        st_valid = sv;
        st_addr  = sa;
        st_size  = ss;
        st_data  = sd;
        st_pc    = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
        ld_valid = lv;
        ld_addr  = la;
        ld_size  = ls;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 2'd0, 32'd0, 1'b0, '0, 2'd0);
    endtask

    initial begin
        // reset state
        idle(2);
        reset = 1'b1;

        // single word store drains next cycle, then buffer empty
        drive(1'b1, 14'h0010, 2'd3, 32'h1234_5678, 1'b0, '0, 2'd0);
        idle(2);

        // illegal stores are dropped
        drive(1'b1, 14'h0003, 2'd1, 32'h0000_BEEF, 1'b0, '0, 2'd0);
        drive(1'b1, 14'h0006, 2'd3, 32'h0BAD_0BAD, 1'b0, '0, 2'd0);
        drive(1'b1, 14'h0008, 2'd2, 32'h0BAD_0BAD, 1'b0, '0, 2'd0);

        // fill with loads owning the port, then full-drain priority
        for (int i = 0; i < 5; i++)
            drive(i < 4, 14'(16'h0030 + 4*i), 2'd3, 32'hA000_0000 + i, 1'b1, 14'h0100, 2'd3);
        drive(1'b0, '0, 2'd0, 32'd0, 1'b1, 14'h0100, 2'd3);
        idle(4);

        // load hitting a pending byte store stalls until it drains
        drive(1'b1, 14'h0021, 2'd0, 32'h0000_00AB, 1'b0, '0, 2'd0);
        drive(1'b0, '0, 2'd0, 32'd0, 1'b1, 14'h0020, 2'd3);
        drive(1'b0, '0, 2'd0, 32'd0, 1'b1, 14'h0020, 2'd3);

        // store into a full buffer while draining is refused, accepted next cycle
        for (int i = 0; i < 4; i++)
            drive(1'b1, 14'(16'h0200 + 4*i), 2'd3, 32'hB000_0000 + i, 1'b1, 14'h0300, 2'd0);
        drive(1'b1, 14'h0210, 2'd3, 32'hB000_0010, 1'b0, '0, 2'd0);
        drive(1'b1, 14'h0210, 2'd3, 32'hB000_0010, 1'b0, '0, 2'd0);
        drive(1'b1, 14'h0214, 2'd1, 32'h0000_1234, 1'b0, '0, 2'd0);
        idle(6);

        // same word stored twice: both reach DM in order
        drive(1'b1, 14'h0400, 2'd3, 32'h1111_1111, 1'b1, 14'h0500, 2'd3);
        drive(1'b1, 14'h0402, 2'd1, 32'h0000_2222, 1'b1, 14'h0500, 2'd3);
        idle(3);

`ifdef STORE_BUFFER_FWD_EN
        drive(1'b1, 14'h0040, 2'd3, 32'hCAFE_F00D, 1'b0, '0, 2'd0);
        drive(1'b0, '0, 2'd0, 32'd0, 1'b1, 14'h0040, 2'd3);
        drive(1'b1, 14'h0040, 2'd3, 32'hFEED_BEEF, 1'b1, 14'h0600, 2'd3);
        drive(1'b0, '0, 2'd0, 32'd0, 1'b1, 14'h0041, 2'd0);
        idle(3);
`endif

        // asynchronous reset with stores pending
        for (int i = 0; i < 3; i++)
            drive(1'b1, 14'(16'h0700 + 4*i), 2'd3, 32'hC000_0000 + i, 1'b1, 14'h0800, 2'd3);
        reset = 1'b0;
        q.delete();
        idle(1);
        reset = 1'b1;
        idle(1);

        // random traffic over a small address window to force hits, wraps and full drains
        for (int i = 0; i < 400; i++) begin
            logic [1:0] ss, ls;
            int         r;
            r  = $urandom_range(0, 9);
            ss = (r < 4) ? 2'd3 : (r < 7) ? 2'd1 : (r < 9) ? 2'd0 : 2'd2;
            r  = $urandom_range(0, 2);
            ls = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : 2'd3;
            drive($urandom_range(0, 99) < 60, 14'($urandom_range(0, 31)), ss, $urandom,
                  $urandom_range(0, 99) < 50, 14'($urandom_range(0, 31)), ls);
        end
        idle(DEPTH + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
